// File: rtl/jtframe_draw_pkg.sv
// Shared definitions for the tile line drawer: FSM states, tile geometry and pixel extraction.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t   - drawer FSM encoding (IDLE, FETCH, SHIFT)
//   draw_yw   - row-index width for a given tile edge
//   draw_pxl  - 4bpp pixel taken from the packed 32-bit shifter
package jtframe_draw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   localparam int WORD_PXL = 8;   // pixels packed in one 32-bit ROM word

   function automatic int draw_yw(input int size);
      return $clog2(size);
   endfunction

   // The four bit planes of a word sit one per byte, so pixel n uses bit n
   // of every byte. With hflip the shifter runs left and pixel 7 comes first.
   function automatic logic [3:0] draw_pxl(input logic [31:0] s, input logic hflip);
      return hflip ? {s[23], s[7], s[31], s[15]} : {s[16], s[0], s[24], s[8]};
   endfunction

endpackage

// File: rtl/jtframe_draw_shift.sv
// 32-bit load/shift register that presents one 4bpp pixel per cycle.
// Latency: pixel reflects the loaded word the cycle after load; shift advances one pixel per cycle.
// Backpressure: none, load has priority over shift.
//
// Ports:
//   rst, clk - asynchronous active-high reset, clock
//   load     - capture data
//   data     - packed ROM word
//   shift    - advance one pixel (left when hflip, else right)
//   hflip    - direction / extraction select
//   pxl      - current 4-bit pixel
module jtframe_draw_shift
   import jtframe_draw_pkg::*;
(
   input  logic        rst,
   input  logic        clk,
   input  logic        load,
   input  logic [31:0] data,
   input  logic        shift,
   input  logic        hflip,
   output logic [3:0]  pxl
);

   logic [31:0] s_q, s_d;

   always_comb begin
      s_d = s_q;
      if (load)
         s_d = data;
      else if (shift)
         s_d = hflip ? {s_q[30:0], 1'b0} : {1'b0, s_q[31:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         s_q <= '0;
      else
         s_q <= s_d;
   end

   assign pxl = draw_pxl(s_q, hflip);

endmodule

// File: rtl/jtframe_draw_gen.sv
// Draws one row of a SIZE x SIZE 4bpp tile into a line buffer, fetching eight pixels per ROM word.
// Latency: first write 3 cycles after draw is accepted; 10 cycles per word with rom_ok high; done after last write.
// Backpressure: rom_ok low stretches FETCH; draw is ignored while busy (no queueing).
//
// Ports:
//   rst, clk           - asynchronous active-high reset, clock
//   draw / busy / done - start request (sampled when idle), line in progress, end-of-line pulse
//   code, xpos, ysub   - tile code, first buffer address, row inside tile
//   hflip, vflip, pal  - flips and palette bits (latched on accept)
//   rom_addr, rom_cs   - 32-bit word address and request, rom_addr stable while rom_cs=1
//   rom_ok, rom_data   - data valid and packed pixels
//   buf_addr, buf_we, buf_din - line-buffer write port, din = {pal, pixel}
module jtframe_draw_gen
   import jtframe_draw_pkg::*;
#(
   parameter int         CW    = 12,
   parameter int         PW    = 8,
   parameter int         SIZE  = 16,
   parameter int         XW    = 9,
   parameter int         TRANS = 1,
   parameter logic [3:0] TPEN  = 4'hf
)(
   input  logic                          rst,
   input  logic                          clk,
   input  logic                          draw,
   output logic                          busy,
   output logic                          done,
   input  logic [CW-1:0]                 code,
   input  logic [XW-1:0]                 xpos,
   input  logic [$clog2(SIZE)-1:0]       ysub,
   input  logic                          hflip,
   input  logic                          vflip,
   input  logic [PW-5:0]                 pal,
   output logic [CW+2*$clog2(SIZE)-4:0]  rom_addr,
   output logic                          rom_cs,
   input  logic                          rom_ok,
   input  logic [31:0]                   rom_data,
   output logic [XW-1:0]                 buf_addr,
   output logic                          buf_we,
   output logic [PW-1:0]                 buf_din
);

   localparam int YW  = draw_yw(SIZE);
   localparam int NW  = SIZE / WORD_PXL;
   // word-index width; a single-word tile keeps a 1-bit index that never moves
   localparam int WWE = (YW > 3) ? YW - 3 : 1;
   localparam logic [WWE-1:0] WLAST = WWE'(NW - 1);
   localparam logic [WWE-1:0] WZERO = '0;
   localparam logic           TR    = (TRANS != 0);

   state_t          state_q;
   logic            busy_q, done_q, rom_cs_q, first_q, hflip_q;
   logic [CW-1:0]   code_q;
   logic [YW-1:0]   ysubf_q;
   logic [PW-5:0]   pal_q;
   logic [XW-1:0]   buf_addr_q;
   logic [WWE-1:0]  widx_q;
   logic [2:0]      cnt_q;
   logic [3:0]      pxl;
   logic            load;

   // The first FETCH cycle after an address change may still see rom_ok
   // from the previous word, so it is never used to capture data.
   assign load = (state_q == ST_FETCH) && !first_q && rom_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rom_cs_q   <= 1'b0;
         first_q    <= 1'b0;
         hflip_q    <= 1'b0;
         code_q     <= '0;
         ysubf_q    <= '0;
         pal_q      <= '0;
         buf_addr_q <= '0;
         widx_q     <= '0;
         cnt_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (draw) begin
                  code_q     <= code;
                  ysubf_q    <= ysub ^ {YW{vflip}};
                  hflip_q    <= hflip;
                  pal_q      <= pal;
                  buf_addr_q <= xpos;
                  widx_q     <= hflip ? WLAST : WZERO;
                  rom_cs_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  first_q    <= 1'b1;
                  state_q    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               first_q <= 1'b0;
               if (load) begin
                  rom_cs_q <= 1'b0;
                  cnt_q    <= 3'd0;
                  state_q  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // address advances on every pixel, written or transparent
               buf_addr_q <= buf_addr_q + 1'b1;
               cnt_q      <= cnt_q + 1'b1;
               if (cnt_q == 3'd7) begin
                  if (widx_q != (hflip_q ? WZERO : WLAST)) begin
                     widx_q   <= hflip_q ? widx_q - 1'b1 : widx_q + 1'b1;
                     rom_cs_q <= 1'b1;
                     first_q  <= 1'b1;
                     state_q  <= ST_FETCH;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   generate
      if (SIZE == 8) begin : g_addr_one
         assign rom_addr = {code_q, ysubf_q[2:0]};
      end else begin : g_addr_multi
         assign rom_addr = {code_q, ysubf_q[YW-1:3], widx_q, ysubf_q[2:0]};
      end
   endgenerate

   jtframe_draw_shift u_shift (
      .rst   (rst),
      .clk   (clk),
      .load  (load),
      .data  (rom_data),
      .shift (state_q == ST_SHIFT),
      .hflip (hflip_q),
      .pxl   (pxl)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign rom_cs   = rom_cs_q;
   assign buf_addr = buf_addr_q;
   assign buf_we   = (state_q == ST_SHIFT) && !(TR && (pxl == TPEN));
   assign buf_din  = {pal_q, pxl};

endmodule

// File: doc/jtframe_draw_gen.md
Name: jtframe_draw_gen

Overview:
- Parametrised line drawer. Renders one line of a square tile of SIZE×SIZE pixels (SIZE = 8, 16 or 32) into a line buffer.
- Fetches 32-bit packed 4bpp words from a tile ROM, eight pixels per word. Supports h/v flip, optional transparent-pen write suppression and a done pulse.
- Sits between a sprite/tile scan engine and a line buffer (jtframe_obj_buffer-style) in the jtframe video pipeline.

Parameters:
- CW, 12, tile code width
- PW, 8, buffer pixel width; pal is PW-4 bits, low 4 bits come from ROM
- SIZE, 16, tile edge in pixels; legal values 8, 16, 32; YW = log2(SIZE)
- XW, 9, line-buffer address width
- TRANS, 1, 1 = pixels equal to TPEN are not written
- TPEN, 4'hf, transparent pen value (4 bits)

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- draw  in  1  start request, sampled only while idle
- busy  out  1  high from the cycle after an accepted draw until line complete
- done  out  1  one-cycle pulse when busy falls
- code  in  CW  tile code
- xpos  in  XW  first buffer address
- ysub  in  YW  row inside tile
- hflip  in  1  horizontal flip
- vflip  in  1  vertical flip
- pal  in  PW-4  palette bits
- rom_addr  out  CW+2*YW-3  32-bit word address
- rom_cs  out  1  ROM request
- rom_ok  in  1  ROM data valid
- rom_data  in  32  packed pixels
- buf_addr  out  XW  line-buffer address
- buf_we  out  1  line-buffer write enable
- buf_din  out  PW  {pal, pixel}

Behaviour:
- Reset values: busy=0, done=0, rom_cs=0, buf_addr=0, shift register=0, state=IDLE. Reset mid-line aborts immediately; no further writes.
- code, ysub, hflip, vflip and pal are latched on accept; inputs may change while busy.
- States:
  - IDLE: on draw, latch inputs, buf_addr<=xpos, widx<=hflip ? last : 0, rom_cs<=1, go to FETCH.
  - FETCH: rom_ok is ignored on the first FETCH cycle (stale data from the previous address). From the second cycle on, rom_ok=1 latches rom_data, sets rom_cs<=0, cnt<=0 and goes to SHIFT.
  - SHIFT: 8 cycles, one pixel per cycle. Each cycle buf_addr+1 (mod 2^XW) and the shifter advances: <<1 if hflip, else >>1. When cnt==7:
    - if words remain: widx steps (+1, or −1 if hflip), rom_cs<=1, go to FETCH;
    - otherwise go to IDLE with busy<=0 and done<=1.
- ysubf = ysub ^ {YW{vflip}}.
- rom_addr:
  - SIZE 8: {code, ysubf[2:0]}.
  - Otherwise: {code, ysubf[YW-1:3], widx, ysubf[2:0]}, with widx of width YW-3.
  - rom_addr is stable whenever rom_cs=1.
- Pixel extraction from the shifter s:
  - hflip=0: {s[16], s[0], s[24], s[8]}.
  - hflip=1: {s[23], s[7], s[31], s[15]}.
- buf_we = SHIFT & ~(TRANS & pixel==TPEN). buf_addr still advances on suppressed pixels.
- buf_din = {pal_latched, pixel}.
- Timing with rom_ok held high, draw sampled at edge 0: FETCH covers cycles 1–2; first write at cycle 3; each word costs 10 cycles. busy lasts 10·SIZE/8 cycles; done pulses the cycle after the last write.
- draw while busy is ignored; no queueing.
- rom_ok dropping while in FETCH simply stretches FETCH. rom_ok in SHIFT is ignored.
- buf_addr wraps from 2^XW−1 to 0 within a line.

Decomposition:
- Package jtframe_draw_pkg holds:
  - state encoding (IDLE, FETCH, SHIFT);
  - a function giving YW from SIZE;
  - a function returning the 4-bit pixel from a 32-bit shifter and hflip.
- One sub-module, jtframe_draw_shift: a 32-bit load/shift register with pixel output. Inputs: load, data, shift, hflip. Output: pxl.
- Top holds the FSM, address generation and counters.

Test Plan:
- SIZE=16, rom_ok=1, xpos=0x1F0, hflip=0, vflip=0, ysub=5, code=0x123:
  - rom_addr = {0x123, 0, 0, 5}, then {0x123, 0, 1, 5};
  - 16 writes to 0x1F0..0x1FF;
  - busy high 20 cycles, done once.
- Same line with hflip=1:
  - word order widx 1 then 0;
  - buf_din sequence is the exact reverse of the unflipped run.
- SIZE=32, vflip=1, ysub=0:
  - ysubf=31; rom_addr rows use ysubf[4:3]=3 and [2:0]=7;
  - 4 fetches; 32 writes.
- TRANS=1, rom_data=0xFFFFFFFF for word 0:
  - no buf_we for pixels 0–7;
  - buf_addr still reaches xpos+8 for word 1.
- xpos=0x1FC, SIZE=8: writes go to 0x1FC..0x1FF then 0x000..0x003.
- Hold rom_ok low for 5 cycles and assert draw during busy: FETCH stretches, the extra draw is ignored. Assert rst mid-SHIFT: buf_we=0, busy=0 and rom_cs=0 immediately.
